// File: rtl/eq_spi_pkg.sv
// Shared definitions for the equalizer coefficient SPI receiver: frame geometry,
// sync word, coefficient field offsets and the receive FSM state encoding.
package eq_spi_pkg;

  localparam int          FRAME_BITS = 336;
  localparam logic [15:0] SYNC_WORD  = 16'hA55A;
  localparam int          SYNC_W     = 16;

  // Coefficients occupy [239:0]: bands low/mid/high, taps b0,b1,b2,a1,a2, MSB first.
  localparam int COEF_W   = 16;
  localparam int N_TAPS   = 5;
  localparam int COEF_MSB = 239;

  function automatic int coef_lsb(input int band, input int tap);
    return COEF_MSB + 1 - COEF_W * (band * N_TAPS + tap + 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset level so idle-high lines do not glitch out of reset.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_coeff_rx.sv
// SPI (mode 0, MSB first) receiver for equalizer coefficient frames; publishes a
// frame on data with a one-cycle update_en pulse once length and sync word check out.
module spi_coeff_rx #(
  parameter int          FRAME_BITS = eq_spi_pkg::FRAME_BITS,
  parameter logic [15:0] SYNC_WORD  = eq_spi_pkg::SYNC_WORD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  sdi,
  input  logic                  cs_n,
  output logic [FRAME_BITS-1:0] data,
  output logic                  update_en,
  output logic                  frame_err
);
  import eq_spi_pkg::*;

  localparam int             CW       = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0]  CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0]  CNT_SAT  = CW'(FRAME_BITS + 1);

  logic sck_s, sdi_s, csn_s;
  logic sck_d_q, csn_d_q;
  logic [1:0] warm_q;
  logic live, sck_rise, cs_fall, cs_rise;

  state_e state_q, state_d;
  logic start, shift_en, accept, reject;

  logic [CW-1:0]         cnt_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] data_q;
  logic                  upd_q;
  logic                  err_q;

  sync2 #(.RST_VAL(1'b0)) u_sync_sck (.clk(clk), .reset(reset), .d_i(sck),  .q_o(sck_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_sdi (.clk(clk), .reset(reset), .d_i(sdi),  .q_o(sdi_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_csn (.clk(clk), .reset(reset), .d_i(cs_n), .q_o(csn_s));

  // Edges are masked until the synchronizers have flushed their reset values, so a
  // cs_n held low across reset release is not mistaken for a fresh falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_d_q <= 1'b0;
      csn_d_q <= 1'b1;
      warm_q  <= 2'd0;
    end else begin
      sck_d_q <= sck_s;
      csn_d_q <= csn_s;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  assign live     = (warm_q == 2'd3);
  assign sck_rise = live &  sck_s & ~sck_d_q;
  assign cs_fall  = live & ~csn_s &  csn_d_q;
  assign cs_rise  = live &  csn_s & ~csn_d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
      ST_SHIFT: if (cs_rise) state_d = ST_CHECK;
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start    = (state_q == ST_IDLE) && cs_fall;
    shift_en = (state_q == ST_SHIFT) && !cs_rise && sck_rise;
    accept   = (state_q == ST_CHECK) && (cnt_q == CNT_FULL) &&
               (shift_q[FRAME_BITS-1 -: SYNC_W] == SYNC_WORD);
    reject   = (state_q == ST_CHECK) && !accept && (cnt_q != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (start) begin
        cnt_q <= '0;
      end else if (shift_en) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], sdi_s};
        if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
      end
      upd_q <= accept;
      if (accept) begin
        data_q <= shift_q;
        err_q  <= 1'b0;
      end else if (reject) begin
        err_q  <= 1'b1;
      end
    end
  end

  assign data      = data_q;
  assign update_en = upd_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_spi_coeff_rx.sv
// Directed bench for spi_coeff_rx: valid, short, bad-sync, overrun, empty,
// reset-interrupted and back-to-back frames driven at sck = clk/8.
module tb_spi_coeff_rx;
  import eq_spi_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sck = 1'b0;
  logic         sdi = 1'b0;
  logic         cs_n = 1'b1;
  logic [335:0] data;
  logic         update_en;
  logic         frame_err;

  int n_vec = 0;
  int n_err = 0;

  spi_coeff_rx dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs_n(cs_n),
    .data(data), .update_en(update_en), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [335:0] obs, input logic [335:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [335:0] mk_frame(input logic [15:0] sync, input logic [15:0] c0,
                                            input logic [15:0] seed, input logic [15:0] lo);
    logic [335:0] f;
    f = '0;
    f[335:320] = sync;
    f[319:240] = {5{seed ^ 16'h5A5A}};
    f[239:224] = c0;
    f[223:16]  = {13{seed}};
    f[15:0]    = lo;
    return f;
  endfunction

  // Sends v[n-1:0] MSB first; each sck phase lasts 4 clk cycles.
  task automatic send_bits(input logic [399:0] v, input int n, input bit end_cs);
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = v[i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    if (end_cs) cs_n = 1'b1;
  endtask

  task automatic watch(input int cycles, output int pulses, output int first,
                       output logic [15:0] lo);
    pulses = 0;
    first  = -1;
    lo     = '0;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      if (update_en === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        lo = data[15:0];
      end
    end
  endtask

  initial begin
    logic [335:0] f1, f2, f3, f4, f5, f6;
    logic [399:0] v;
    int pulses, first, pa, pb;
    logic [15:0] lo, loa, lob;

    f1 = mk_frame(16'hA55A, 16'h2000, 16'h1357, 16'h1234);
    f2 = mk_frame(16'hA55A, 16'h0F0F, 16'hC3C3, 16'hBEEF);
    f3 = mk_frame(16'hA55B, 16'h7777, 16'h2468, 16'h4321);
    f4 = mk_frame(16'hA55A, 16'h3333, 16'h9ABC, 16'h00FF);
    f5 = mk_frame(16'hA55A, 16'h1111, 16'h0F1E, 16'h0001);
    f6 = mk_frame(16'hA55A, 16'h2222, 16'hE1F0, 16'h0002);

    repeat (3) @(negedge clk);
    chk("rst_data", data, '0);
    chk("rst_upd", 336'(update_en), 336'(1'b0));
    chk("rst_err", 336'(frame_err), 336'(1'b0));
    reset = 1'b0;
    repeat (5) @(negedge clk);

    send_bits(400'(f1), 336, 1'b1);
    watch(12, pulses, first, lo);
    chk("valid_pulses", 336'(pulses), 336'(1));
    chk("valid_latency", 336'(first >= 1 && first <= 5), 336'(1));
    chk("valid_data", data, f1);
    chk("valid_coef", 336'(data[coef_lsb(0, 0) +: 16]), 336'(16'h2000));
    chk("valid_err", 336'(frame_err), 336'(1'b0));

    send_bits(400'(f2 >> 1), 335, 1'b1);
    watch(12, pulses, first, lo);
    chk("short_pulses", 336'(pulses), 336'(0));
    chk("short_data", data, f1);
    chk("short_err", 336'(frame_err), 336'(1'b1));

    send_bits(400'(f2), 336, 1'b1);
    watch(12, pulses, first, lo);
    chk("recover_pulses", 336'(pulses), 336'(1));
    chk("recover_data", data, f2);
    chk("recover_err", 336'(frame_err), 336'(1'b0));

    send_bits(400'(f3), 336, 1'b1);
    watch(12, pulses, first, lo);
    chk("badsync_pulses", 336'(pulses), 336'(0));
    chk("badsync_data", data, f2);
    chk("badsync_err", 336'(frame_err), 336'(1'b1));

    send_bits(400'(f1), 336, 1'b1);
    watch(12, pulses, first, lo);
    chk("clear_pulses", 336'(pulses), 336'(1));
    chk("clear_err", 336'(frame_err), 336'(1'b0));

    v = {64'h0, f4, 4'hA};
    send_bits(v, 340, 1'b1);
    watch(12, pulses, first, lo);
    chk("overrun_pulses", 336'(pulses), 336'(0));
    chk("overrun_data", data, f1);
    chk("overrun_err", 336'(frame_err), 336'(1'b1));

    @(negedge clk);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    watch(12, pulses, first, lo);
    chk("empty_pulses", 336'(pulses), 336'(0));
    chk("empty_err", 336'(frame_err), 336'(1'b1));

    send_bits(400'(f2 >> 236), 100, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_data", data, '0);
    chk("midrst_err", 336'(frame_err), 336'(1'b0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    cs_n = 1'b1;
    watch(12, pulses, first, lo);
    chk("postrst_pulses", 336'(pulses), 336'(0));
    chk("postrst_data", data, '0);
    send_bits(400'(f4), 336, 1'b1);
    watch(12, pulses, first, lo);
    chk("postrst_valid_pulses", 336'(pulses), 336'(1));
    chk("postrst_valid_data", data, f4);

    send_bits(400'(f5), 336, 1'b1);
    watch(4, pa, first, loa);
    send_bits(400'(f6), 336, 1'b1);
    watch(12, pb, first, lob);
    chk("b2b_pulses_1", 336'(pa), 336'(1));
    chk("b2b_lo_1", 336'(loa), 336'(16'h0001));
    chk("b2b_pulses_2", 336'(pb), 336'(1));
    chk("b2b_lo_2", 336'(lob), 336'(16'h0002));
    chk("b2b_data", data, f6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
